// File: rtl/hk_spi_pkg.sv
// Shared definitions for the housekeeping SPI host.
// Holds the command opcodes the housekeeping slave understands, the
// smallest legal SCK half-period and the host FSM state encoding.
package hk_spi_pkg;

  localparam logic [7:0] HK_CMD_WRITE_STREAM = 8'h80;
  localparam logic [7:0] HK_CMD_READ_STREAM  = 8'h40;

  // Below this the 2-flop sdi synchroniser cannot settle before sampling.
  localparam int MIN_CLK_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    ADDR,
    WAIT_WR,
    DATA,
    HOLD,
    GAP
  } hk_state_e;

endpackage

// File: rtl/hk_spi_shifter.sv
// Bit engine for the housekeeping SPI host (SPI mode 0, MSB first).
// Owns the SCK divider, the 8-bit shift register, the bit counter and the
// sdi synchroniser.
//   clk, RST   : system clock, synchronous active-low reset
//   load       : capture byte_in and restart the bit timing with sck low
//   byte_in    : byte to transmit
//   go         : run the divider; when low, sck is parked at 0
//   sdi        : serial data from the slave (asynchronous)
//   sck        : serial clock
//   sdo_bit    : current transmit bit (shift register MSB)
//   byte_done  : high during the last clk of the 8th SCK-high phase
//   byte_out   : received byte, complete while byte_done is high
module hk_spi_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       go,
  input  logic       sdi,
  output logic       sck,
  output logic       sdo_bit,
  output logic       byte_done,
  output logic [7:0] byte_out
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [1:0] sdi_sync;
  logic       phase_end;

  assign phase_end = go && (div_cnt == DIV_LAST);
  assign byte_done = phase_end && sck && (bit_cnt == 3'd7);
  // The synchronised bit joins the byte on the last clk of the high phase.
  assign byte_out  = {shreg[6:0], sdi_sync[1]};
  assign sdo_bit   = shreg[7];

  // NOTE: state registers use non-blocking assignments so every flop in
  // the design samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!RST) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      sdi_sync <= '0;
      sck      <= 1'b0;
    end else begin
      sdi_sync <= {sdi_sync[0], sdi};
      if (load) begin
        shreg   <= byte_in;
        div_cnt <= '0;
        bit_cnt <= '0;
        sck     <= 1'b0;
      end else if (!go) begin
        div_cnt <= '0;
        sck     <= 1'b0;
      end else if (phase_end) begin
        div_cnt <= '0;
        sck     <= ~sck;
        // Falling edge: shift so the next transmit bit appears on sdo at
        // the start of the low phase, together with the captured bit.
        if (sck) begin
          shreg   <= byte_out;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/hk_spi_host.sv
// Hardware SPI host for the housekeeping SPI slave in mgmt_soc_hk.
// Issues a streaming read (0x40) or write (0x80) command, the start address
// and len data bytes, with byte handshakes on the local side.
//   clk, RST            : system clock, synchronous active-low reset
//   start, cmd_write    : request a transaction (sampled only in IDLE)
//   addr, len           : register start address, data byte count (1..255)
//   wr_data/valid/ready : write byte stream; wr_ready pulses on consumption
//   rd_data/rd_valid    : received byte, rd_valid pulses when new
//   busy, done          : transaction in progress, end-of-transaction pulse
//   sck, csb, sdo, sdi  : SPI pins towards the housekeeping slave
module hk_spi_host
  import hk_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic       cmd_write,
  input  logic [7:0] addr,
  input  logic [7:0] len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       csb,
  output logic       sdo,
  input  logic       sdi
);

  localparam logic [7:0] WAIT_LAST = 8'(CLK_DIV - 1);

  hk_state_e  state, state_next;
  logic       write_q;
  logic [7:0] addr_q;
  logic [7:0] remain_q;
  logic [7:0] wait_cnt;
  logic       wait_last;
  logic       accept;

  logic       load, go, byte_done, sdo_bit;
  logic [7:0] byte_in, byte_out;

  hk_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk       (clk),
    .RST       (RST),
    .load      (load),
    .byte_in   (byte_in),
    .go        (go),
    .sdi       (sdi),
    .sck       (sck),
    .sdo_bit   (sdo_bit),
    .byte_done (byte_done),
    .byte_out  (byte_out)
  );

  assign accept    = (state == IDLE) && start && (len != 8'd0);
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign busy      = (state != IDLE);
  assign csb       = (state == IDLE) || (state == GAP);
  // Read data phases and all idle states drive a quiet 0 on sdo.
  assign sdo       = sdo_bit && ((state == CMD) || (state == ADDR) ||
                                 ((state == DATA) && write_q));

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    byte_in    = '0;
    go         = 1'b0;
    wr_ready   = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP: begin
        if (wait_last) begin
          load       = 1'b1;
          byte_in    = write_q ? HK_CMD_WRITE_STREAM : HK_CMD_READ_STREAM;
          state_next = CMD;
        end
      end
      CMD: begin
        go = 1'b1;
        if (byte_done) begin
          load       = 1'b1;
          byte_in    = addr_q;
          state_next = ADDR;
        end
      end
      ADDR: begin
        go = 1'b1;
        if (byte_done) begin
          if (write_q) begin
            state_next = WAIT_WR;
          end else begin
            load       = 1'b1;
            state_next = DATA;
          end
        end
      end
      WAIT_WR: begin
        if (wr_valid) begin
          wr_ready   = 1'b1;
          load       = 1'b1;
          byte_in    = wr_data;
          state_next = DATA;
        end
      end
      DATA: begin
        go = 1'b1;
        if (byte_done) begin
          if (remain_q == 8'd1) state_next = HOLD;
          else if (write_q)     state_next = WAIT_WR;
          else                  load       = 1'b1;
        end
      end
      HOLD:    if (wait_last) state_next = GAP;
      GAP: begin
        if (wait_last) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
      wait_cnt <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_next;
      rd_valid <= 1'b0;
      if (accept) begin
        write_q  <= cmd_write;
        addr_q   <= addr;
        remain_q <= len;
      end
      // wait_cnt times the SETUP/HOLD/GAP phases and restarts on each change.
      if (state != state_next) begin
        wait_cnt <= '0;
      end else if ((state == SETUP) || (state == HOLD) || (state == GAP)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if ((state == DATA) && byte_done) begin
        remain_q <= remain_q - 8'd1;
        if (!write_q) begin
          rd_valid <= 1'b1;
          rd_data  <= byte_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_hk_spi_host.sv
// Directed bench for hk_spi_host with a behavioural housekeeping slave.
module tb_hk_spi_host;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0, start2 = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] addr = 8'h00, len = 8'h00, wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready, rd_valid, busy, done, sck, csb, sdo;
  logic [7:0] rd_data;
  logic       sdi = 1'b0;

  logic       wr_ready2, rd_valid2, busy2, done2, sck2, csb2, sdo2;
  logic [7:0] rd_data2;
  logic       sdi2 = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hk_spi_host #(.CLK_DIV(4)) u_dut (
    .clk(clk), .RST(RST), .start(start), .cmd_write(cmd_write), .addr(addr),
    .len(len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .sck(sck), .csb(csb), .sdo(sdo), .sdi(sdi)
  );

  hk_spi_host #(.CLK_DIV(6)) u_dut6 (
    .clk(clk), .RST(RST), .start(start2), .cmd_write(cmd_write), .addr(addr),
    .len(len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready2),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .done(done2),
    .sck(sck2), .csb(csb2), .sdo(sdo2), .sdi(sdi2)
  );

  // Behavioural housekeeping slave: streaming read/write, mode 0.
  logic [7:0] s_mem [256];
  logic [7:0] s_sh = 8'h00, s_cmd = 8'h00, s_addr = 8'h00, s_tx = 8'h00;
  int         s_bits = 0, s_byte = 0;
  logic [7:0] rx_log [$];

  initial begin
    for (int i = 0; i < 256; i++) s_mem[i] = 8'h00;
    s_mem[1] = 8'h04;
    s_mem[2] = 8'h56;
  end

  always @(negedge csb) begin
    s_bits = 0;
    s_byte = 0;
    s_tx   = 8'h00;
    sdi    = 1'b0;
  end

  always @(posedge sck) if (csb === 1'b0) begin
    s_sh   = {s_sh[6:0], sdo};
    s_bits = s_bits + 1;
    if (s_bits == 8) begin
      s_bits = 0;
      rx_log.push_back(s_sh);
      if (s_byte == 0) s_cmd = s_sh;
      else if (s_byte == 1) s_addr = s_sh;
      else if (s_cmd == 8'h80) begin
        s_mem[s_addr] = s_sh;
        s_addr = s_addr + 8'd1;
      end
      s_byte = s_byte + 1;
    end
  end

  always @(negedge sck) if (csb === 1'b0) begin
    if (s_cmd == 8'h40 && s_byte >= 2 && s_bits == 0) begin
      s_tx   = s_mem[s_addr];
      s_addr = s_addr + 8'd1;
    end else begin
      s_tx = {s_tx[6:0], 1'b0};
    end
    sdi = s_tx[7];
  end

  // Results of the most recent run_txn.
  logic [7:0] wbytes [4];
  logic [7:0] res_rd [$];
  int res_wrr, res_done, res_cyc, res_stall_bad, res_stall_seen;
  bit res_timeout;

  // Runs one transaction on u_dut; optionally stalls wr_valid before byte
  // stall_idx for stall_len cycles after the previous byte has shifted out.
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] n,
                         input int stall_idx, input int stall_len);
    int  since;
    int  idx;
    bit  stalled;
    res_rd.delete();
    rx_log.delete();
    res_wrr = 0; res_done = 0; res_cyc = 0;
    res_stall_bad = 0; res_stall_seen = 0; res_timeout = 1;
    since = 1000000;
    idx = 0;
    @(negedge clk);
    cmd_write = w; addr = a; len = n; start = 1'b1; wr_valid = 1'b0;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_valid) res_rd.push_back(rd_data);
      if (w && idx == stall_idx && since >= 65 && since < 64 + stall_len) begin
        res_stall_seen++;
        if (sck !== 1'b0 || csb !== 1'b0) res_stall_bad++;
      end
      if (w) begin
        stalled  = (idx == stall_idx) && (since < 64 + stall_len);
        wr_valid = (idx < int'(n)) && !stalled;
        if (idx < 4) wr_data = wbytes[idx];
      end
      if (done) begin res_done++; res_cyc = c; end
      #1;
      if (wr_ready) begin res_wrr++; idx++; since = 0; end
      else since++;
      if (done) begin res_timeout = 0; break; end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (csb !== 1'b1) begin tests_failed++; $display("FAIL reset_csb got %b want 1", csb); end
    tests_run++; if (sck !== 1'b0) begin tests_failed++; $display("FAIL reset_sck got %b want 0", sck); end
    tests_run++; if (sdo !== 1'b0) begin tests_failed++; $display("FAIL reset_sdo got %b want 0", sdo); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    RST = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_id();
    logic [7:0] got;
    run_txn(1'b0, 8'h01, 8'd2, -1, 0);
    tests_run++; if (res_timeout !== 1'b0) begin tests_failed++; $display("FAIL read_timeout got %b want 0", res_timeout); end
    got = (rx_log.size() > 0) ? rx_log[0] : 8'hxx;
    tests_run++; if (got !== 8'h40) begin tests_failed++; $display("FAIL read_cmd_byte got %h want 40", got); end
    got = (rx_log.size() > 1) ? rx_log[1] : 8'hxx;
    tests_run++; if (got !== 8'h01) begin tests_failed++; $display("FAIL read_addr_byte got %h want 01", got); end
    tests_run++; if (res_rd.size() !== 2) begin tests_failed++; $display("FAIL read_rd_valid_count got %0d want 2", res_rd.size()); end
    got = (res_rd.size() > 0) ? res_rd[0] : 8'hxx;
    tests_run++; if (got !== 8'h04) begin tests_failed++; $display("FAIL read_byte0 got %h want 04", got); end
    got = (res_rd.size() > 1) ? res_rd[1] : 8'hxx;
    tests_run++; if (got !== 8'h56) begin tests_failed++; $display("FAIL read_byte1 got %h want 56", got); end
    tests_run++; if (res_cyc !== 268) begin tests_failed++; $display("FAIL read_done_cycle got %0d want 268", res_cyc); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL read_busy_after_done got %b want 0", busy); end
  endtask

  task automatic test_stream_write();
    logic [7:0] exp_log [5];
    logic [7:0] exp_rd [3];
    logic [7:0] got;
    wbytes[0] = 8'hA5; wbytes[1] = 8'h5A; wbytes[2] = 8'hFF; wbytes[3] = 8'h00;
    exp_log[0] = 8'h80; exp_log[1] = 8'h08; exp_log[2] = 8'hA5; exp_log[3] = 8'h5A; exp_log[4] = 8'hFF;
    exp_rd[0] = 8'hA5; exp_rd[1] = 8'h5A; exp_rd[2] = 8'hFF;
    run_txn(1'b1, 8'h08, 8'd3, 1, 50);
    tests_run++; if (res_timeout !== 1'b0) begin tests_failed++; $display("FAIL write_timeout got %b want 0", res_timeout); end
    tests_run++; if (rx_log.size() !== 5) begin tests_failed++; $display("FAIL write_sdo_count got %0d want 5", rx_log.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (rx_log.size() > i) ? rx_log[i] : 8'hxx;
      tests_run++; if (got !== exp_log[i]) begin tests_failed++; $display("FAIL write_sdo_byte%0d got %h want %h", i, got, exp_log[i]); end
    end
    tests_run++; if (res_wrr !== 3) begin tests_failed++; $display("FAIL write_wr_ready_count got %0d want 3", res_wrr); end
    tests_run++; if (res_stall_seen !== 49) begin tests_failed++; $display("FAIL write_stall_window got %0d want 49", res_stall_seen); end
    tests_run++; if (res_stall_bad !== 0) begin tests_failed++; $display("FAIL write_stall_pins got %0d want 0", res_stall_bad); end
    tests_run++; if (res_rd.size() !== 0) begin tests_failed++; $display("FAIL write_no_rd_valid got %0d want 0", res_rd.size()); end
    run_txn(1'b0, 8'h08, 8'd3, -1, 0);
    tests_run++; if (res_rd.size() !== 3) begin tests_failed++; $display("FAIL readback_count got %0d want 3", res_rd.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (res_rd.size() > i) ? res_rd[i] : 8'hxx;
      tests_run++; if (got !== exp_rd[i]) begin tests_failed++; $display("FAIL readback_byte%0d got %h want %h", i, got, exp_rd[i]); end
    end
  endtask

  task automatic test_guards();
    int bad, done_cnt, done_at, extra_busy;
    logic [7:0] got;
    logic [7:0] rd_q [$];
    @(negedge clk);
    cmd_write = 1'b0; addr = 8'h01; len = 8'd0; start = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b0 || done !== 1'b0 || csb !== 1'b1 || sck !== 1'b0) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL len0_ignored got %0d bad cycles want 0", bad); end

    done_cnt = 0; done_at = 0; extra_busy = 0;
    cmd_write = 1'b0; addr = 8'h01; len = 8'd2; start = 1'b1;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 100) begin cmd_write = 1'b1; addr = 8'h20; len = 8'd1; start = 1'b1; end
      if (c == 101) begin cmd_write = 1'b0; addr = 8'h01; len = 8'd2; end
      if (rd_valid) rd_q.push_back(rd_data);
      if (done_cnt > 0 && busy) extra_busy++;
      if (done) begin done_cnt++; done_at = c; end
    end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL busy_guard_done_count got %0d want 1", done_cnt); end
    tests_run++; if (done_at !== 268) begin tests_failed++; $display("FAIL busy_guard_done_cycle got %0d want 268", done_at); end
    tests_run++; if (extra_busy !== 0) begin tests_failed++; $display("FAIL busy_guard_restart got %0d busy cycles want 0", extra_busy); end
    got = (rd_q.size() > 1) ? rd_q[1] : 8'hxx;
    tests_run++; if (got !== 8'h56) begin tests_failed++; $display("FAIL busy_guard_byte1 got %h want 56", got); end
  endtask

  task automatic test_timing();
    int hi_run, lo_run, hi_bad, lo_bad, n_hi, setup_cnt, hold_cnt, sdo_bad;
    logic prev_sck, prev_csb, prev_sdo;
    bit finished;
    hi_run = 0; lo_run = 0; hi_bad = 0; lo_bad = 0; n_hi = 0;
    setup_cnt = -1; hold_cnt = -1; sdo_bad = 0; finished = 0;
    prev_sck = 1'b0; prev_csb = 1'b1; prev_sdo = 1'b0;
    @(negedge clk);
    cmd_write = 1'b0; addr = 8'hC3; len = 8'd1; start2 = 1'b1;
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (csb2 === 1'b0) begin
        if (sck2) begin
          if (!prev_sck) begin
            if (n_hi == 0) setup_cnt = lo_run;
            else if (lo_run != 6) lo_bad++;
            lo_run = 0;
          end
          hi_run++;
          if (sdo2 !== prev_sdo) sdo_bad++;
        end else begin
          if (prev_sck) begin
            if (hi_run != 6) hi_bad++;
            n_hi++;
            hi_run = 0;
          end
          lo_run++;
        end
      end else if (prev_csb === 1'b0) begin
        hold_cnt = lo_run;
      end
      prev_sck = sck2; prev_csb = csb2; prev_sdo = sdo2;
      if (done2) begin finished = 1; break; end
    end
    tests_run++; if (finished !== 1'b1) begin tests_failed++; $display("FAIL timing_done got %b want 1", finished); end
    tests_run++; if (n_hi !== 24) begin tests_failed++; $display("FAIL timing_sck_pulses got %0d want 24", n_hi); end
    tests_run++; if (hi_bad !== 0) begin tests_failed++; $display("FAIL timing_high_phase got %0d bad want 0", hi_bad); end
    tests_run++; if (lo_bad !== 0) begin tests_failed++; $display("FAIL timing_low_phase got %0d bad want 0", lo_bad); end
    tests_run++; if (setup_cnt < 6) begin tests_failed++; $display("FAIL timing_csb_setup got %0d want >=6", setup_cnt); end
    tests_run++; if (hold_cnt < 6) begin tests_failed++; $display("FAIL timing_csb_hold got %0d want >=6", hold_cnt); end
    tests_run++; if (sdo_bad !== 0) begin tests_failed++; $display("FAIL timing_sdo_stable got %0d changes want 0", sdo_bad); end
  endtask

  task automatic test_reset_mid();
    int rises, rv_seen;
    logic prev_sck;
    bit reached;
    logic [7:0] got;
    rises = 0; rv_seen = 0; reached = 0; prev_sck = 1'b0;
    @(negedge clk);
    cmd_write = 1'b0; addr = 8'h01; len = 8'd1; start = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
      // 8 command + 8 address rises, then the 3rd bit of the data byte.
      if (rises == 19) begin reached = 1; RST = 1'b0; break; end
    end
    tests_run++; if (reached !== 1'b1) begin tests_failed++; $display("FAIL rstmid_reach_bit got %b want 1", reached); end
    @(negedge clk);
    tests_run++; if (csb !== 1'b1) begin tests_failed++; $display("FAIL rstmid_csb got %b want 1", csb); end
    tests_run++; if (sck !== 1'b0) begin tests_failed++; $display("FAIL rstmid_sck got %b want 0", sck); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_rd_data got %h want 00", rd_data); end
    if (rd_valid) rv_seen++;
    @(negedge clk);
    if (rd_valid) rv_seen++;
    RST = 1'b1;
    repeat (3) begin @(negedge clk); if (rd_valid) rv_seen++; end
    tests_run++; if (rv_seen !== 0) begin tests_failed++; $display("FAIL rstmid_rd_valid got %0d want 0", rv_seen); end
    run_txn(1'b0, 8'h02, 8'd1, -1, 0);
    got = (res_rd.size() > 0) ? res_rd[0] : 8'hxx;
    tests_run++; if (res_rd.size() !== 1) begin tests_failed++; $display("FAIL rstmid_next_count got %0d want 1", res_rd.size()); end
    tests_run++; if (got !== 8'h56) begin tests_failed++; $display("FAIL rstmid_next_byte got %h want 56", got); end
    tests_run++; if (res_cyc !== 204) begin tests_failed++; $display("FAIL rstmid_next_cycle got %0d want 204", res_cyc); end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_stream_write();
    test_guards();
    test_timing();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hk_spi_host.md
Name: hk_spi_host

Overview:
- Hardware SPI host that drives the housekeeping SPI slave inside mgmt_soc_hk.
- Connects through mgmt_io_in[4:2] (SCK/CSB/SDI) and mgmt_io_out[1] (SDO).
- Replaces bench-task bit-banging so FPGA logic (or a UART bridge) can issue housekeeping streaming read/write transactions.
- Generates the command byte, the address byte and N data bytes, with byte-level handshakes on the local side.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period. Legal values are 4..255; below 4 the sdi synchroniser cannot settle.

Ports:
- clk  in  1  system clock
- RST  in  1  synchronous, active-low reset
- start  in  1  transaction request; sampled only in IDLE
- cmd_write  in  1  1 = streaming write (command 0x80); 0 = streaming read (command 0x40)
- addr  in  8  housekeeping register start address
- len  in  8  number of data bytes, 1..255
- wr_data  in  8  next write byte
- wr_valid  in  1  wr_data is valid
- wr_ready  out  1  one-cycle pulse; the write byte is consumed
- rd_data  out  8  last received byte
- rd_valid  out  1  one-cycle pulse; rd_data is new
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- sck  out  1  to mgmt_io_in[4]
- csb  out  1  to mgmt_io_in[3]
- sdo  out  1  to mgmt_io_in[2] (slave SDI)
- sdi  in  1  from mgmt_io_out[1] (slave SDO)

Behaviour:
- Reset (RST=0 at a clk edge), effective immediately including mid-transaction:
  - csb=1, sck=0, sdo=0, busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=0x00.
  - FSM goes to IDLE. No partial byte is reported.
- SPI mode 0, MSB first:
  - sdo changes only while sck=0, at the start of the low phase.
  - The slave samples on the SCK rising edge.
- sdi path and sampling:
  - sdi passes through a 2-flop synchroniser.
  - The synchronised value is captured on the last clk of each SCK-high phase.
- Bit timing: each bit is CLK_DIV clk cycles with sck=0, then CLK_DIV with sck=1.
- FSM states: IDLE, SETUP, CMD, ADDR, WAIT_WR, DATA, HOLD, GAP.
  - IDLE: start=1 and len!=0 → latch cmd_write/addr/len, set busy=1 on the next cycle, go to SETUP. start with len=0 is ignored (no busy, no done).
  - SETUP: csb=0 for CLK_DIV cycles with sck=0 → CMD.
  - CMD: shift 0x80 or 0x40 → ADDR.
  - ADDR: shift addr → WAIT_WR if writing, else DATA.
  - WAIT_WR: sck held 0 and csb held 0 while wr_valid=0. When wr_valid=1, pulse wr_ready, load the byte, go to DATA. A stall of any length is legal.
  - DATA: shift one byte. On reads, sdo=0, and rd_valid pulses one clk after the 8th sample.
    - When the byte finishes: decrement the remaining count; if it reaches 0 → HOLD.
    - Otherwise → WAIT_WR (write) or next DATA (read).
  - HOLD: sck=0, csb=0 for CLK_DIV cycles, then csb=1 → GAP.
  - GAP: csb=1 for CLK_DIV cycles. In the last cycle done=1; busy=0 from the following cycle. → IDLE.
- Bytes are not pipelined: in a write, byte k+1 is requested only after byte k finishes shifting.
- start while busy=1 is ignored (no queueing).
- Cycle count for a read with zero stalls, from start to the done pulse inclusive: CLK_DIV + (2+len)·16·CLK_DIV + 2·CLK_DIV. Example: CLK_DIV=4, len=2 → 4+256+8 = 268.
- Counter widths: divider 8 bits, bit counter 3 bits, byte counter 8 bits. No wrap occurs, because len≥1 is checked at start.

Decomposition:
- Package hk_spi_pkg holds:
  - HK_CMD_WRITE_STREAM=8'h80 and HK_CMD_READ_STREAM=8'h40
  - the FSM state enum
  - MIN_CLK_DIV=4
- One natural sub-module, hk_spi_shifter. It owns the divider, the 8-bit shift register, the bit counter and the sdi synchroniser.
  - Interface: load/byte_in/go → byte_done/byte_out.
  - hk_spi_host holds the FSM and byte counting.

Test Plan:
- Manufacturer ID read: start, cmd_write=0, addr=0x01, len=2, against the housekeeping slave → sdo carries 0x40 then 0x01; rd_valid pulses twice with rd_data 0x04 then 0x56; done at cycle 268 (CLK_DIV=4).
- Streaming write: cmd_write=1, addr=0x08, len=3, bytes 0xA5/0x5A/0xFF, wr_valid held low 50 cycles before byte 2 → sdo shows 0x80, 0x08, 0xA5, 0x5A, 0xFF; sck stays 0 and csb stays 0 during the stall; exactly 3 wr_ready pulses; readback returns the same bytes.
- Timing check: CLK_DIV=6 → sck high and low phases are each 6 clk; csb setup and hold are ≥6 clk; sdo is stable whenever sck=1.
- len=0 and busy guards: start with len=0 → busy, done and csb unchanged. start pulsed mid-transaction → ignored; exactly one done pulse.
- Reset mid-DATA: RST=0 at the 3rd bit of a data byte → next cycle csb=1, sck=0, busy=0, no rd_valid. A following 1-byte read completes correctly.
